// File: rtl/vdp_bus_pkg.sv
// Shared types and constants for the Z80-style I/O bus toward the VDP port decoder.
package vdp_bus_pkg;

  // Bus cycle phases of the I/O master
  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_GAP
  } z80io_state_t;

  // VDP port map
  localparam logic [7:0] VDP_DATA_PORT   = 8'hBE;
  localparam logic [7:0] VDP_CTRL_PORT   = 8'hBF;
  localparam logic [7:0] VDP_VCOUNT_PORT = 8'h7E;

  // Counter widths: wait states are 0..3, idle gap is 1..7
  localparam int unsigned WAIT_W = 2;
  localparam int unsigned GAP_W  = 3;

  // True when a port address hits one of the VDP ports
  function automatic logic is_vdp_port(input logic [7:0] port);
    return (port == VDP_DATA_PORT) || (port == VDP_CTRL_PORT) ||
           (port == VDP_VCOUNT_PORT);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer whose flops reset to 1 (idle level of an active-low line).
module sync2 (
  input  logic clk,
  input  logic rst_L,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the asynchronous input twice before use
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z80_io_master.sv
// Z80-style I/O cycle initiator: host requests plus autonomous VDP IRQ status reads.
module z80_io_master
  import vdp_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned IDLE_GAP    = 1,
  parameter int unsigned IRQ_HOLDOFF = 8
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_port,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       irq_en,
  output logic       status_valid,
  output logic [7:0] status_data,
  input  logic       INT_L,
  output logic [7:0] addr_bus_out,
  output logic [7:0] data_bus_out,
  output logic       data_oe,
  input  logic [7:0] data_bus_in,
  output logic       IORQ_L,
  output logic       RD_L,
  output logic       WR_L,
  output logic       M1_L,
  output logic       busy
);

  localparam int unsigned HOLD_W = (IRQ_HOLDOFF < 2) ? 1 : $clog2(IRQ_HOLDOFF + 1);

  z80io_state_t      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] holdoff;
  logic              is_irq;
  logic              is_write;
  logic              int_sync;
  logic              irq_take;

  // No interrupt-acknowledge cycles are ever issued
  assign M1_L = 1'b1;

  sync2 u_int_sync (
    .clk   (clk),
    .rst_L (rst_L),
    .d     (INT_L),
    .q     (int_sync)
  );

  // IRQ service wins the IDLE slot; ready is a decode of flops plus the enable
  assign irq_take  = irq_en && !int_sync && (holdoff == '0);
  assign req_ready = (state == S_IDLE) && !irq_take;

  // Bus cycle sequencer with registered strobes, address, data and responses
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      holdoff      <= '0;
      is_irq       <= 1'b0;
      is_write     <= 1'b0;
      IORQ_L       <= 1'b1;
      RD_L         <= 1'b1;
      WR_L         <= 1'b1;
      addr_bus_out <= 8'h00;
      data_bus_out <= 8'h00;
      data_oe      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      status_valid <= 1'b0;
      status_data  <= 8'h00;
      busy         <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      status_valid <= 1'b0;
      if (holdoff != '0) begin
        holdoff <= holdoff - HOLD_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (irq_take) begin
            is_irq       <= 1'b1;
            is_write     <= 1'b0;
            addr_bus_out <= VDP_CTRL_PORT;
            data_bus_out <= 8'h00;
            data_oe      <= 1'b0;
            busy         <= 1'b1;
            state        <= S_T1;
          end else if (req_valid) begin
            is_irq       <= 1'b0;
            is_write     <= req_write;
            addr_bus_out <= req_port;
            data_bus_out <= req_write ? req_wdata : 8'h00;
            data_oe      <= req_write;
            busy         <= 1'b1;
            state        <= S_T1;
          end
        end

        S_T1: begin
          IORQ_L <= 1'b0;
          RD_L   <= is_write;
          WR_L   <= !is_write;
          state  <= S_T2;
        end

        S_T2: begin
          wait_cnt <= WAIT_W'(1);
          state    <= (WAIT_STATES == 0) ? S_T3 : S_TW;
        end

        S_TW: begin
          if (wait_cnt == WAIT_W'(WAIT_STATES)) begin
            state <= S_T3;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_T3: begin
          IORQ_L  <= 1'b1;
          RD_L    <= 1'b1;
          WR_L    <= 1'b1;
          data_oe <= 1'b0;
          gap_cnt <= GAP_W'(1);
          state   <= S_GAP;
          if (is_irq) begin
            status_valid <= 1'b1;
            status_data  <= data_bus_in;
            holdoff      <= HOLD_W'(IRQ_HOLDOFF);
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= is_write ? 8'h00 : data_bus_in;
          end
        end

        S_GAP: begin
          if (gap_cnt >= GAP_W'(IDLE_GAP)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          IORQ_L <= 1'b1;
          RD_L   <= 1'b1;
          WR_L   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/z80_io_master.md
# z80_io_master

Bus-initiator that issues Z80-style I/O read/write cycles (IORQ_L/RD_L/WR_L with T1/T2/TW/T3 timing) toward the VDP port decoder on ports 0xBE/0xBF/0x7E. It replaces the CPU for bring-up and host-driven VRAM/register loading. It accepts single-transaction requests over a valid/ready handshake and returns read data or write completion. It also services VDP interrupts autonomously by reading the status port (0xBF), which clears the VDP flags.

## Interface
- WAIT_STATES, 1, TW cycles between T2 and T3; legal 0..3. The VDP decoder requires ≤1, giving a strobe-low width ≤3 clocks.
- IDLE_GAP, 1, cycles with strobes high after T3 before the next cycle may start; legal 1..7.
- IRQ_HOLDOFF, 8, cycles after an IRQ service completes during which INT_L is ignored.
- clk  in  1  bus clock; single clock domain.
- rst_L  in  1  asynchronous active-low reset.
- req_valid / req_ready  in/out  1  request handshake; transfer on the clock edge where both are high.
- req_write  in  1  1 = I/O write, 0 = I/O read.
- req_port  in  8  I/O port address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse for host requests.
- rsp_rdata  out  8  read data; 0 for writes.
- irq_en  in  1  enables autonomous interrupt service.
- status_valid  out  1  one-cycle pulse when an IRQ status read completes.
- status_data  out  8  captured status byte.
- INT_L  in  1  VDP interrupt, active low, asynchronous to clk.
- addr_bus_out  out  8  port address.
- data_bus_out  out  8  write data; data_oe  out  1  write-data enable.
- data_bus_in  in  8  read data from the VDP.
- IORQ_L, RD_L, WR_L, M1_L  out  1  bus strobes, active low. M1_L is tied high; no IM-mode acknowledge cycles are issued.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, T1, T2, TW, T3, GAP.
- IDLE:
  - If irq_take (irq_en & INT_L synchronized low & holdoff counter = 0), latch an internal read of 0xBF and go to T1. req_ready is low in that cycle.
  - Otherwise req_ready = 1. On handshake, latch write/port/wdata and go to T1.
  - IRQ service has priority when it coincides with req_valid.
- T1: addr_bus_out = latched port. All strobes high. data_oe = write.
- T2: IORQ_L = 0 and, per direction, RD_L = 0 or WR_L = 0. If WAIT_STATES = 0, go to T3; else go to TW.
- TW: strobes held low. Counter runs to WAIT_STATES, then go to T3.
- T3: strobes held low. On the closing edge of T3, capture data_bus_in for reads, deassert all strobes, and go to GAP.
- GAP:
  - Strobes are high; addr_bus_out and data_bus_out hold their values; data_oe = 0.
  - In the first GAP cycle, pulse rsp_valid (host request) or status_valid (IRQ service).
  - After IDLE_GAP cycles, go to IDLE.
- IRQ service completion loads the holdoff counter with IRQ_HOLDOFF. The counter decrements to 0 each cycle.
- INT_L passes through a 2-flop synchronizer whose flops reset to 1.
- A host request arriving in TW/T3/GAP waits; req_ready stays 0 until IDLE.

## Timing
- Reset values: state IDLE; IORQ_L, RD_L, WR_L, M1_L = 1; addr_bus_out, data_bus_out, rsp_rdata, status_data = 0; data_oe, rsp_valid, status_valid, busy = 0; req_ready = 1 (synchronizer reads deasserted).
- Assertion of rst_L mid-cycle forces strobes high immediately (asynchronously). The in-flight transaction is dropped and produces no response pulse.
- Timeline at defaults, with the handshake at edge e0:
  - T1 spans e0–e1, T2 e1–e2, TW e2–e3, T3 e3–e4.
  - Read data is sampled at e4.
  - rsp_valid is high e4–e5 (GAP); IDLE begins at e5.
  - Earliest next handshake is e6, giving one transaction per 6 clocks.
- Strobe-low width = 2 + WAIT_STATES clocks, contiguous, with no glitch between T2/TW/T3. All outputs are registered.
- Worst-case INT_L-to-T1 latency is 2 synchronizer cycles + 1 IDLE cycle. Add the remaining transaction length if INT_L falls mid-transaction.

## Structure
- Shared package vdp_bus_pkg holds:
  - the state enum (z80io_state_t);
  - port constants VDP_DATA_PORT = 8'hBE, VDP_CTRL_PORT = 8'hBF, VDP_VCOUNT_PORT = 8'h7E.
- One sub-module, sync2, is the 2-flop reset-to-1 synchronizer for INT_L. Everything else lives in z80_io_master.

## Test plan
- Write 0xBF with data 0x81 (defaults) -> WR_L and IORQ_L low for exactly 3 clocks, addr = 0xBF, data_oe over T1–T3, rsp_valid 1 cycle with rsp_rdata = 0, decoder enters WR0/WR1 exactly once.
- Read 0xBE with the VDP driving 0x5A -> RD_L low for 3 clocks, rsp_rdata = 0x5A on the rsp_valid cycle, e0-to-rsp_valid = 4 clocks.
- req_valid held high for three back-to-back writes -> handshakes 6 clocks apart, strobes high ≥1 clock between cycles, no decoder double-trigger.
- irq_en = 1, INT_L low, VDP status = 0x80 -> read of 0xBF, status_valid with 0x80, no rsp_valid, next service no earlier than IRQ_HOLDOFF cycles after GAP even if INT_L stays low.
- INT_L falls and req_valid rises in the same IDLE cycle after synchronization -> IRQ read first with req_ready = 0, host request accepted in the following IDLE.
- rst_L pulsed low during TW of a write -> strobes high in the same cycle, no rsp_valid, after release state IDLE with req_ready = 1.
